// File: rtl/fifo_sample_reader_pkg.sv
// Shared audio-path definitions: reader state encoding and underrun counter sizing.
package fifo_sample_reader_pkg;

  localparam logic [1:0] st_prime_code   = 2'd0;
  localparam logic [1:0] st_ready_code   = 2'd1;
  localparam logic [1:0] st_capture_code = 2'd2;

  typedef enum logic [1:0] {
    st_prime   = st_prime_code,
    st_ready   = st_ready_code,
    st_capture = st_capture_code
  } reader_state_t;

  localparam int unsigned count_width = 16;
  localparam logic [count_width-1:0] count_max = '1;

endpackage

// File: rtl/fifo_sample_reader.sv
// Pulls one sample from the playback FIFO per sample tick and hands it to the DAC path,
// substituting silence while priming or on underrun.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// st_prime   | waiting for enable and fill >= start_level; ticks give silence
// st_ready   | primed; a tick issues a FIFO read (or an underrun if empty)
// st_capture | FIFO read data valid this cycle; latch it into sample_out
module fifo_sample_reader
  import fifo_sample_reader_pkg::*;
#(
  parameter int data_width    = 16,
  parameter int address_width = 4,
  parameter int start_level   = 8
) (
  input  logic                          r_clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          sample_tick,
  input  logic signed [data_width-1:0]  fifo_data_out,
  input  logic                          fifo_empty,
  input  logic [address_width-1:0]      fifo_data_fill,
  output logic                          fifo_rd_en,
  output logic signed [data_width-1:0]  sample_out,
  output logic                          sample_valid,
  output logic                          underrun,
  output logic                          missed_tick,
  output logic [count_width-1:0]        underrun_count
);

  localparam logic [address_width-1:0] start_fill = address_width'(start_level);

  reader_state_t          state;
  logic [count_width-1:0] underrun_cnt;
  logic                   level_ok;
  logic                   fetch;

  assign level_ok       = fifo_data_fill >= start_fill;
  assign fetch          = (state == st_ready) && enable && sample_tick && !fifo_empty;
  // Gated by reset so a read can never be issued while the block is being cleared.
  assign fifo_rd_en     = fetch && !reset;
  assign underrun_count = underrun_cnt;

  always_ff @(posedge r_clk) begin
    if (reset) begin
      state        <= st_prime;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
      missed_tick  <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
      missed_tick  <= 1'b0;
      case (state)
        st_prime: begin
          if (sample_tick) begin
            sample_out   <= '0;
            sample_valid <= 1'b1;
          end
          if (enable && level_ok) state <= st_ready;
        end
        st_ready: begin
          if (!enable) begin
            if (sample_tick) begin
              sample_out   <= '0;
              sample_valid <= 1'b1;
            end
            state <= st_prime;
          end else if (sample_tick && fifo_empty) begin
            sample_out   <= '0;
            sample_valid <= 1'b1;
            underrun     <= 1'b1;
            if (underrun_cnt != count_max) underrun_cnt <= underrun_cnt + count_width'(1);
            state        <= st_prime;
          end else if (sample_tick) begin
            state <= st_capture;
          end
        end
        st_capture: begin
          // A tick here cannot start another fetch; it is only flagged.
          sample_out   <= fifo_data_out;
          sample_valid <= 1'b1;
          missed_tick  <= sample_tick;
          state        <= enable ? st_ready : st_prime;
        end
        default: state <= st_prime;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_sample_reader.sv
// Scoreboard bench for fifo_sample_reader: directed scenarios followed by random traffic.
module tb_fifo_sample_reader;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int START = 8;

  logic                 r_clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 enable = 1'b0;
  logic                 sample_tick = 1'b0;
  logic signed [DW-1:0] fifo_data_out = '0;
  logic                 fifo_empty = 1'b1;
  logic [AW-1:0]        fifo_data_fill = '0;
  logic                 fifo_rd_en;
  logic signed [DW-1:0] sample_out;
  logic                 sample_valid;
  logic                 underrun;
  logic                 missed_tick;
  logic [15:0]          underrun_count;

  always #5 r_clk = ~r_clk;

  fifo_sample_reader #(.data_width(DW), .address_width(AW), .start_level(START)) dut (
    .r_clk(r_clk), .reset(reset), .enable(enable), .sample_tick(sample_tick),
    .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty), .fifo_data_fill(fifo_data_fill),
    .fifo_rd_en(fifo_rd_en), .sample_out(sample_out), .sample_valid(sample_valid),
    .underrun(underrun), .missed_tick(missed_tick), .underrun_count(underrun_count)
  );

  typedef struct {
    int                   cyc;
    logic signed [DW-1:0] data;
    bit                   urun;
    logic [15:0]          cnt;
  } exp_t;

  exp_t sq[$];
  int   mq[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  bit   exp_rd = 1'b0;
  bit   mon_on = 1'b0;

  // Reference model: 0 = priming, 1 = primed, 2 = fetched word arrives this cycle.
  int                   phase = 0;
  logic signed [DW-1:0] fetched = '0;
  logic signed [DW-1:0] plan_val = '0;
  bit                   have_plan = 1'b0;
  logic [15:0]          m_cnt = '0;

  always @(posedge r_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int c, input logic signed [DW-1:0] d, input bit u, input logic [15:0] n);
    exp_t e;
    e.cyc = c; e.data = d; e.urun = u; e.cnt = n;
    sq.push_back(e);
  endtask

  task automatic step(input bit rst, input bit en, input bit tk, input int fill, input bit emp);
    @(posedge r_clk);
    #1;
    reset          = rst;
    enable         = en;
    sample_tick    = tk;
    fifo_data_fill = fill[AW-1:0];
    fifo_empty     = emp;
    exp_rd         = 1'b0;
    fifo_data_out  = (phase == 2) ? fetched : DW'($urandom);
    if (rst) begin
      phase = 0;
      m_cnt = '0;
    end else begin
      case (phase)
        0: begin
          if (tk) push_exp(cyc + 1, '0, 1'b0, m_cnt);
          if (en && fill >= START) phase = 1;
        end
        1: begin
          if (!en) begin
            if (tk) push_exp(cyc + 1, '0, 1'b0, m_cnt);
            phase = 0;
          end else if (tk && emp) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            push_exp(cyc + 1, '0, 1'b1, m_cnt);
            phase = 0;
          end else if (tk) begin
            exp_rd    = 1'b1;
            fetched   = have_plan ? plan_val : DW'($urandom);
            have_plan = 1'b0;
            phase     = 2;
          end
        end
        default: begin
          push_exp(cyc + 1, fetched, 1'b0, m_cnt);
          if (tk) mq.push_back(cyc + 1);
          phase = en ? 1 : 0;
        end
      endcase
    end
  endtask

  always @(negedge r_clk) begin
    if (mon_on) begin
      exp_t e;
      chk("rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_rd});
      if (sample_valid) begin
        if (sq.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_valid: got sample_valid=1 with no sample expected (cycle %0d)", cyc);
        end else begin
          e = sq.pop_front();
          chk("valid_cycle", cyc, e.cyc);
          chk("sample", {16'd0, sample_out}, {16'd0, e.data});
          chk("underrun_flag", {31'd0, underrun}, {31'd0, e.urun});
          if (e.urun) chk("underrun_count", {16'd0, underrun_count}, {16'd0, e.cnt});
        end
      end else if (sq.size() > 0 && sq[0].cyc <= cyc) begin
        checks++; fails++;
        $display("FAIL missing_valid: got no sample_valid expected one at cycle %0d", sq[0].cyc);
        void'(sq.pop_front());
      end
      if (underrun && !sample_valid) begin
        checks++; fails++;
        $display("FAIL lone_underrun: got underrun=1 with sample_valid=0 (cycle %0d)", cyc);
      end
      if (missed_tick) begin
        if (mq.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_missed: got missed_tick=1 expected 0 (cycle %0d)", cyc);
        end else chk("missed_cycle", cyc, mq.pop_front());
      end else if (mq.size() > 0 && mq[0] <= cyc) begin
        checks++; fails++;
        $display("FAIL missing_missed: got missed_tick=0 expected 1 at cycle %0d", mq[0]);
        void'(mq.pop_front());
      end
    end
  end

  initial begin
    logic signed [DW-1:0] neg_val;
    int fill;
    neg_val = -16'sd1234;

    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    mon_on = 1'b1;
    step(0, 0, 0, 0, 1);
    chk("reset_sample", {16'd0, sample_out}, 32'd0);
    chk("reset_count", {16'd0, underrun_count}, 32'd0);
    chk("reset_valid", {31'd0, sample_valid}, 32'd0);

    // Priming holds below start level; ticks there give silence, not reads.
    step(0, 1, 0, 7, 0);
    step(0, 1, 1, 7, 0);
    step(0, 1, 0, 7, 0);
    step(0, 1, 0, 8, 0);
    plan_val = 16'sh7FFF; have_plan = 1'b1;
    step(0, 1, 1, 8, 0);
    step(0, 1, 0, 8, 0);
    step(0, 1, 0, 8, 0);
    chk("max_sample", {16'd0, sample_out}, 32'h7FFF);

    plan_val = neg_val; have_plan = 1'b1;
    step(0, 1, 1, 8, 0);
    step(0, 1, 0, 8, 0);
    step(0, 1, 0, 8, 0);
    step(0, 1, 0, 8, 0);
    chk("neg_sign", {16'd0, sample_out}, {16'd0, neg_val});

    // Back-to-back ticks: second is reported as missed.
    step(0, 1, 1, 8, 0);
    step(0, 1, 1, 8, 0);
    step(0, 1, 0, 8, 0);
    step(0, 1, 0, 8, 0);

    step(0, 1, 1, 8, 1);
    step(0, 1, 0, 0, 1);
    chk("underrun_one", {16'd0, underrun_count}, 32'd1);
    step(0, 1, 1, 8, 0);
    step(0, 1, 0, 8, 0);

    // Reset lands on the capture cycle: fetched word must be dropped.
    step(0, 1, 1, 8, 0);
    step(1, 1, 0, 8, 0);
    step(0, 1, 0, 8, 0);
    chk("rst_capture_sample", {16'd0, sample_out}, 32'd0);
    chk("rst_capture_count", {16'd0, underrun_count}, 32'd0);

    force dut.underrun_cnt = 16'hFFFF;
    #1;
    release dut.underrun_cnt;
    m_cnt = 16'hFFFF;
    step(0, 1, 1, 8, 1);
    step(0, 1, 0, 8, 0);
    chk("count_saturate", {16'd0, underrun_count}, 32'h0000FFFF);

    for (int i = 0; i < 3000; i++) begin
      fill = int'($urandom_range(0, 15));
      if ($urandom % 4 == 0) fill = 0;
      step(($urandom % 300) == 0, ($urandom % 16) != 0, ($urandom % 4) == 0, fill, fill == 0);
    end
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8, 0);
    @(negedge r_clk);
    #1;
    chk("samples_drained", sq.size(), 32'd0);
    chk("missed_drained", mq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fifo_sample_reader.md
FIFO_SAMPLE_READER -- requirements
Module: fifo_sample_reader

Interface
REQ-001 SHALL have parameter data_width, default 16, sample width in bits (signed).
REQ-002 SHALL have parameter address_width, default 4, width of the FIFO fill level.
REQ-003 SHALL have parameter start_level, default 8, fill level needed to leave priming; legal range 1..2^address_width-1.
REQ-004 SHALL have port r_clk, input, 1, the single clock (FIFO read clock); one clock, all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port enable, input, 1, run request; low forces priming state and no reads.
REQ-007 SHALL have port sample_tick, input, 1, one-cycle audio sample-rate strobe.
REQ-008 SHALL have port fifo_data_out, input, data_width signed, FIFO registered read data.
REQ-009 SHALL have port fifo_empty, input, 1, FIFO empty flag.
REQ-010 SHALL have port fifo_data_fill, input, address_width, FIFO fill level.
REQ-011 SHALL have port fifo_rd_en, output, 1, FIFO read strobe.
REQ-012 SHALL have port sample_out, output reg, data_width signed, sample presented downstream.
REQ-013 SHALL have port sample_valid, output, 1, one-cycle pulse when sample_out is updated.
REQ-014 SHALL have port underrun, output, 1, one-cycle pulse on a tick that found the FIFO empty.
REQ-015 SHALL have port missed_tick, output, 1, one-cycle pulse on a tick arriving while a fetch is in progress.
REQ-016 SHALL have port underrun_count, output, 16, saturating count of underruns.

Function
REQ-017 SHALL implement states PRIME, READY, CAPTURE.
REQ-018 PRIME: fifo_rd_en=0; go to READY when enable=1 and fifo_data_fill>=start_level.
REQ-019 PRIME, sample_tick=1: sample_out<=0, sample_valid pulses next cycle (DAC rate kept, silence).
REQ-020 READY, sample_tick=1, fifo_empty=0: fifo_rd_en=1 combinationally same cycle T; next state CAPTURE.
REQ-021 CAPTURE (cycle T+1): sample_out<=fifo_data_out; sample_valid=1 in cycle T+2; next state READY.
REQ-022 Latency tick-to-sample_valid SHALL be exactly 2 cycles for a fetched sample.
REQ-023 fifo_rd_en SHALL be high only in the READY-tick cycle, at most one cycle per tick, never when fifo_empty=1.
REQ-024 READY, sample_tick=1, fifo_empty=1: sample_out<=0, sample_valid and underrun pulse in T+1, underrun_count+1 (saturate at 16'hFFFF), next state PRIME.
REQ-025 CAPTURE, sample_tick=1: tick ignored, missed_tick pulses in T+1, capture completes normally.
REQ-026 enable=0 in READY: next state PRIME, no read; enable=0 in CAPTURE: capture completes, then PRIME.
REQ-027 sample_out SHALL hold its last value between updates; sample_valid never high for two consecutive cycles.
REQ-028 fifo_data_fill SHALL be compared unsigned; no arithmetic on samples (pass-through, sign preserved).

Reset
REQ-029 reset=1 SHALL, at the next r_clk edge, set state PRIME, sample_out=0, underrun_count=0, sample_valid/underrun/missed_tick=0.
REQ-030 fifo_rd_en SHALL be 0 while reset=1, including reset asserted mid-CAPTURE (in-flight sample discarded).

Structure
REQ-031 State encoding and underrun_count width SHALL be localparams in a shared audio package.
REQ-032 No sub-module SHALL be instantiated; the block connects beside sync_fifo at the top level.

Verification
REQ-033 Fill=7 then 8, enable=1 -> PRIME until fill=8, then READY; tick -> rd_en at T, sample_valid at T+2 with fifo value 16'sh7FFF.
REQ-034 Negative sample -16'sd1234 fetched -> sample_out=-1234 exactly, sign intact.
REQ-035 Tick with fifo_empty=1 in READY -> sample_out=0, underrun pulse at T+1, underrun_count=1, state PRIME, no rd_en.
REQ-036 Tick at T and T+1 -> one rd_en, one sample_valid at T+2, missed_tick at T+2.
REQ-037 reset at CAPTURE cycle -> no sample_valid, sample_out=0, count=0; underrun_count preset 16'hFFFF plus underrun -> stays 16'hFFFF.
